// File: rtl/demux14_router.sv
// -----------------------------------------------------------------------------
// demux14_router
// Registered 1-to-4 demultiplexer with valid/ready handshakes. Each input beat
// carries a 2-bit select and is steered into one of four single-entry holding
// registers (channels a, b, c, d). No combinational path exists from in_data
// to any output data; accept-to-out_valid latency is exactly one cycle.
//
// Optional feature macro: DEMUX_CNT_EN
//   When defined, per-channel saturating accepted-beat counters are added and
//   exposed on a_cnt..d_cnt. When undefined, those ports and counters are absent.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input beat valid
//   in_sel     in   2      destination: 0=a, 1=b, 2=c, 3=d
//   in_data    in   WIDTH  input beat payload
//   in_ready   out  1      beat accepted when in_valid & in_ready
//   a..d_data  out  WIDTH  channel holding-register contents
//   out_valid  out  4      per-channel valid (bit0=a .. bit3=d)
//   out_ready  in   4      per-channel consumer ready (same order)
//   a..d_cnt   out  CNT_W  accepted-beat counters (DEMUX_CNT_EN only)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module demux14_router #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  output logic [WIDTH-1:0] c_data,
  output logic [WIDTH-1:0] d_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] c_cnt,
  output logic [CNT_W-1:0] d_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [3:0]       w_full;
  logic [3:0]       w_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_data [4];

  // Ready depends only on the selected channel: free, or draining this cycle.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = !w_full[0] || out_ready[0];
      2'd1:    in_ready = !w_full[1] || out_ready[1];
      2'd2:    in_ready = !w_full[2] || out_ready[2];
      2'd3:    in_ready = !w_full[3] || out_ready[3];
      default: in_ready = 1'b1;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    state_t           r_state;
    logic [WIDTH-1:0] r_data;

    assign w_load[k] = w_accept && (in_sel == 2'(k));

    // Channel state and holding register; a load wins over a drain so
    // back-to-back beats keep the channel FULL with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= EMPTY;
        r_data  <= '0;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_load[k]) begin
              r_state <= FULL;
              r_data  <= in_data;
            end else begin
              r_state <= EMPTY;
            end
          end
          FULL: begin
            if (w_load[k]) begin
              r_data  <= in_data;
            end else if (out_ready[k]) begin
              r_state <= EMPTY;
            end else begin
              r_state <= FULL;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end

    assign w_full[k] = (r_state == FULL);
    assign w_data[k] = r_data;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count of beats accepted into this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_load[k] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
`endif
  end

  assign out_valid = w_full;
  assign a_data    = w_data[0];
  assign b_data    = w_data[1];
  assign c_data    = w_data[2];
  assign d_data    = w_data[3];

`ifdef DEMUX_CNT_EN
  assign a_cnt = g_ch[0].r_cnt;
  assign b_cnt = g_ch[1].r_cnt;
  assign c_cnt = g_ch[2].r_cnt;
  assign d_cnt = g_ch[3].r_cnt;
`endif

endmodule

// File: tb/tb_demux14_router.sv
// -----------------------------------------------------------------------------
// tb_demux14_router
// Directed bench for demux14_router with hand-computed expected values.
// Inputs are changed 1ns after the rising edge; registered outputs are
// sampled at the same point, combinational in_ready 1ns after inputs change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux14_router;

`ifdef DEMUX_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 8;
`endif
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] a_data, b_data, c_data, d_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef DEMUX_CNT_EN
  logic [TB_CNT_W-1:0] a_cnt, b_cnt, c_cnt, d_cnt;
`endif

  int chk_cnt;
  int pass_cnt;

  demux14_router #(.WIDTH(WIDTH), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .a_data    (a_data),
    .b_data    (b_data),
    .c_data    (c_data),
    .d_data    (d_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
    ,
    .a_cnt     (a_cnt),
    .b_cnt     (b_cnt),
    .c_cnt     (c_cnt),
    .d_cnt     (d_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 8'h00;
    out_ready = 4'b0000;

    // Reset and idle
    #1;
    check("ready_in_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_a", 32'(a_data), 32'h0);
    check("rst_b", 32'(b_data), 32'h0);
    check("rst_c", 32'(c_data), 32'h0);
    check("rst_d", 32'(d_data), 32'h0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Don't-care select/data with in_valid low changes nothing
    in_sel  = 2'd1;
    in_data = 8'hFF;
    step();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_b", 32'(b_data), 32'h0);

    // Single beat to channel c
    send(2'd2, 8'hA5);
    check("c_valid", 32'(out_valid), 32'h4);
    check("c_data", 32'(c_data), 32'hA5);
    check("c_other_a", 32'(a_data), 32'h0);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    check("c_drained", 32'(out_valid), 32'h0);

    // Blocked channel a, independent channel b
    send(2'd0, 8'h11);
    check("a_valid", 32'(out_valid), 32'h1);
    check("a_data", 32'(a_data), 32'h11);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'h22;
    #1;
    check("a_blocked_ready", 32'(in_ready), 32'd0);
    step();
    check("a_hold", 32'(a_data), 32'h11);
    check("a_hold_valid", 32'(out_valid), 32'h1);
    in_sel  = 2'd1;
    in_data = 8'h33;
    #1;
    check("b_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("b_data", 32'(b_data), 32'h33);
    check("ab_valid", 32'(out_valid), 32'h3);
    check("a_still", 32'(a_data), 32'h11);

    // Drain and reload a on the same edge
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h22;
    #1;
    check("a_drain_ready", 32'(in_ready), 32'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    check("a_reload", 32'(a_data), 32'h22);
    check("a_reload_valid", 32'(out_valid), 32'h3);

    // Drain a and b together while loading c
    out_ready = 4'b0011;
    send(2'd2, 8'h5C);
    out_ready = 4'b0000;
    check("multi_valid", 32'(out_valid), 32'h4);
    check("multi_c", 32'(c_data), 32'h5C);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check("all_drained", 32'(out_valid), 32'h0);

    // Stream to d with consumer always ready
    out_ready = 4'b1000;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 8'(i);
      #1;
      check($sformatf("d_stream_ready%0d", i), 32'(in_ready), 32'd1);
      step();
      check($sformatf("d_stream_data%0d", i), 32'(d_data), 32'(i));
      check($sformatf("d_stream_valid%0d", i), 32'(out_valid), 32'h8);
    end
    in_valid = 1'b0;
    step();
    out_ready = 4'b0000;
    check("d_stream_end", 32'(out_valid), 32'h0);

`ifdef DEMUX_CNT_EN
    check("cnt_a_mid", 32'(a_cnt), 32'd2);
    check("cnt_d_mid", 32'(d_cnt), 32'd5);
`endif

    // Fill all channels, then reset between edges
    send(2'd0, 8'h40);
    send(2'd1, 8'h41);
    send(2'd2, 8'h42);
    send(2'd3, 8'h43);
    check("all_full", 32'(out_valid), 32'hF);
    check("all_full_d", 32'(d_data), 32'h43);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_a", 32'(a_data), 32'h0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX_CNT_EN
    check("async_rst_cnt_b", 32'(b_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 32'(out_valid), 32'h0);

`ifdef DEMUX_CNT_EN
    // Saturation of channel b counter at 15
    out_ready = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      send(2'd1, 8'(i));
    end
    out_ready = 4'b0000;
    check("cnt_b_sat", 32'(b_cnt), 32'd15);
    check("cnt_a_zero", 32'(a_cnt), 32'd0);
    check("cnt_c_zero", 32'(c_cnt), 32'd0);
    check("cnt_d_zero", 32'(d_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/demux14_router.md
Name: demux14_router

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes; the inverse of the mux41 4:1 selector.
- Takes one input stream tagged with a 2-bit select and steers each beat into one of four output holding registers (a, b, c, d).
- Sits on the producer side feeding four consumers, and also serves as a stimulus source for the mux41 bench.
- One clock domain, no combinational path from in_data to any output data.

Parameters:
- WIDTH, 8, data width of input and each output channel.
- CNT_W, 8, width of per-channel beat counters (only used when DEMUX_CNT_EN is defined).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_sel  input  2  destination: 0=a, 1=b, 2=c, 3=d.
- in_data  input  WIDTH  input beat payload.
- in_ready  output  1  input beat accepted this cycle when in_valid & in_ready.
- a_data, b_data, c_data, d_data  output  WIDTH each  channel holding-register contents.
- out_valid  output  4  per-channel valid; bit0=a, bit1=b, bit2=c, bit3=d.
- out_ready  input  4  per-channel consumer ready, same bit order.
- a_cnt, b_cnt, c_cnt, d_cnt  output  CNT_W each  accepted-beat counters; present only with DEMUX_CNT_EN.

Behaviour:
- Reset (async assert, sync release): out_valid=4'b0000, all *_data=0, all counters=0. in_ready is combinational and reads as 1 during reset.
- Each channel k has one register holding a data word and a valid bit (full_k).
- in_ready = !full[in_sel] || out_ready[in_sel]. It depends only on the selected channel; a stall on another channel never blocks.
- Accept (in_valid & in_ready): on the next edge, channel in_sel loads in_data and sets full. Latency is exactly 1 cycle from accept to out_valid.
- Drain (out_valid[k] & out_ready[k]): full_k clears on the next edge unless the same edge loads a new beat.
- Simultaneous drain and load on the same channel: new data loads, full stays 1, giving back-to-back throughput of 1 beat per cycle per channel.
- Simultaneous drains on several channels plus a load on a different channel are all independent.
- Per-channel state, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load, or on no drain.
- Holding data is stable while out_valid[k]=1 and out_ready[k]=0. An output never drops valid before the handshake.
- in_sel and in_data are don't-care when in_valid=0; no state changes.
- Reset mid-operation: in-flight beats are discarded and all channels return to EMPTY asynchronously.
- out_ready on an EMPTY channel has no effect.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined:
  - a_cnt..d_cnt ports exist.
  - Counter k increments by 1 on each accept to channel k.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - Counters clear to 0 on reset only.
- Not defined: the counter ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle, all out_ready=0 -> out_valid=0000, all data 0, in_ready=1.
- in_valid=1, in_sel=2, in_data=8'hA5 for one cycle -> next cycle out_valid=0100, c_data=A5. Other channels unchanged.
- Fill channel a (sel=0, 8'h11) with out_ready[0]=0, then present sel=0, 8'h22:
  - in_ready=0 while blocked; a_data holds 11.
  - Present sel=1, 8'h33 -> in_ready=1, and b gets 33 next cycle.
- Stream sel=3 for 5 cycles with data 1..5 and out_ready[3]=1 -> in_ready stays 1. d_data shows 1..5 on consecutive cycles, one cycle after each accept, with no bubbles.
- Load all four channels, assert rst_n=0 mid-cycle -> out_valid=0000 immediately, before the next clock edge.
- With DEMUX_CNT_EN and CNT_W=4: send 20 beats to channel b -> b_cnt=15 (saturated), a_cnt=c_cnt=d_cnt=0.
